// File: rtl/down_counter8_pkg.sv
// down_counter8_pkg: widths and active-low 7-segment table shared by the down_counter8 slice.
package down_counter8_pkg;
    localparam int PRE_W = 32;
    localparam int CNT_W = 3;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [7:0][6:0] SEG_TABLE = {SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seg7_decode3.sv
// seg7_decode3: combinational 3-bit value to active-low 7-segment pattern (bit 0 = a, bit 6 = g).
module seg7_decode3
    import down_counter8_pkg::*;
(
    input  logic [CNT_W-1:0] q,
    output logic [6:0]       seg
);
    assign seg = SEG_TABLE[q];
endmodule

// File: rtl/down_counter8.sv
// down_counter8: prescaled 3-bit down counter with load, borrow pulse and 7-segment output.
// Define DOWN_COUNTER8_AUTOSTOP_EN for one-shot mode (stops at 0 instead of wrapping).
module down_counter8
    import down_counter8_pkg::*;
#(
    parameter int unsigned DIV_TIMES = 100000000
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             iEn,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iPreset,
    output logic [CNT_W-1:0] oQ,
    output logic             oBorrow,
    output logic [6:0]       oDisplay
);
    localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV_TIMES - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             borrow_next;
    logic [CNT_W-1:0] q_next;

    assign tick = iEn && !iLoad && pre == LAST;

`ifdef DOWN_COUNTER8_AUTOSTOP_EN
    assign borrow_next = tick && oQ == CNT_W'(1);
    assign q_next      = (oQ == '0) ? oQ : oQ - 1'b1;
`else
    assign borrow_next = tick && oQ == '0;
    assign q_next      = oQ - 1'b1;
`endif

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pre     <= '0;
            oQ      <= '0;
            oBorrow <= 1'b0;
        end else begin
            oBorrow <= borrow_next;
            if (iLoad) begin
                oQ  <= iPreset;
                pre <= '0;
            end else if (iEn) begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick)
                    oQ <= q_next;
            end
        end
    end

    seg7_decode3 u_seg (
        .q   (oQ),
        .seg (oDisplay)
    );
endmodule

// File: tb/tb_down_counter8.sv
// tb_down_counter8: directed checks of down_counter8 with DIV_TIMES=4 and DIV_TIMES=1 instances.
module tb_down_counter8;
    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, load = 1'b0, en1 = 1'b0, load1 = 1'b0;
    logic [2:0] preset = '0, preset1 = '0;
    logic [2:0] q, q1;
    logic       b, b1;
    logic [6:0] d, d1;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef DOWN_COUNTER8_AUTOSTOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [2:0] WRAP_Q = AUTO ? 3'd0 : 3'd7;
    localparam logic [2:0] NEXT_Q = AUTO ? 3'd0 : 3'd6;
    localparam logic       WRAP_B = !AUTO;
    localparam logic [6:0] EXP_SEG [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    always #5 CLK = ~CLK;

    down_counter8 #(.DIV_TIMES(4)) dut4 (
        .CLK(CLK), .rst(rst), .iEn(en), .iLoad(load), .iPreset(preset),
        .oQ(q), .oBorrow(b), .oDisplay(d)
    );

    down_counter8 #(.DIV_TIMES(1)) dut1 (
        .CLK(CLK), .rst(rst), .iEn(en1), .iLoad(load1), .iPreset(preset1),
        .oQ(q1), .oBorrow(b1), .oDisplay(d1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        // inputs are ignored while reset is held
        en = 1'b1; load = 1'b1; preset = 3'd5;
        step(1);
        chk("rst_q", q, 0); chk("rst_b", b, 0); chk("rst_disp", d, 7'h40);
        rst = 1'b0; load = 1'b0;
        step(3);  chk("cnt_pre_tick", q, 0);
        step(1);  chk("cnt_wrap_q", q, WRAP_Q); chk("cnt_wrap_b", b, WRAP_B); chk("cnt_wrap_disp", d, EXP_SEG[WRAP_Q]);
        step(1);  chk("cnt_b_clear", b, 0); chk("cnt_hold_q", q, WRAP_Q);
        step(3);  chk("cnt_next_q", q, NEXT_Q); chk("cnt_next_disp", d, EXP_SEG[NEXT_Q]);

        load = 1'b1; preset = 3'd3;
        step(1);  chk("load3_q", q, 3); load = 1'b0;
        step(3);  chk("tick_pending_q", q, 3);
        load = 1'b1; preset = 3'd5;
        step(1);  chk("load_prio_q", q, 5); chk("load_prio_b", b, 0); load = 1'b0;
        step(3);  chk("after_load_hold", q, 5);
        step(1);  chk("after_load_dec", q, 4);

        for (int i = 0; i < 7; i++) begin
            en = (i % 2 == 0);
            step(1);
            if (i == 5) chk("gate_3en_q", q, 4);
        end
        chk("gate_4en_q", q, 3);
        en = 1'b0;
        step(20); chk("en_low_q", q, 3); chk("en_low_b", b, 0);
        en = 1'b1;
        step(3);  chk("en_resume_hold", q, 3);
        step(1);  chk("en_resume_dec", q, 2);

        load = 1'b1; preset = 3'd4;
        step(1);  load = 1'b0;
        step(1);
        #2 rst = 1'b1;
        #1 chk("async_q", q, 0); chk("async_disp", d, 7'h40);
        @(negedge CLK) rst = 1'b0;
        step(3);  chk("post_rst_hold", q, 0);
        step(1);  chk("post_rst_q", q, WRAP_Q); chk("post_rst_b", b, WRAP_B);
        #2 rst = 1'b1;
        #1 chk("rst_kills_b", b, 0);
        @(negedge CLK) rst = 1'b0;

`ifdef DOWN_COUNTER8_AUTOSTOP_EN
        load = 1'b1; preset = 3'd2;
        step(1);  load = 1'b0; chk("auto_q2", q, 2);
        step(4);  chk("auto_q1", q, 1); chk("auto_b_q1", b, 0);
        step(4);  chk("auto_q0", q, 0); chk("auto_b_pulse", b, 1);
        step(1);  chk("auto_b_clear", b, 0);
        step(16); chk("auto_stay_q", q, 0); chk("auto_stay_b", b, 0);
`endif

        en = 1'b0;
        load1 = 1'b1; preset1 = 3'd7;
        step(1);  chk("sweep_q7", q1, 7); chk("sweep_disp7", d1, EXP_SEG[7]);
        load1 = 1'b0; en1 = 1'b1;
        for (int k = 6; k >= 0; k--) begin
            step(1);
            chk($sformatf("sweep_q%0d", k), q1, k);
            chk($sformatf("sweep_disp%0d", k), d1, EXP_SEG[k]);
            chk($sformatf("sweep_b%0d", k), b1, AUTO && k == 0);
        end
        step(1);  chk("sweep_wrap_q", q1, WRAP_Q); chk("sweep_wrap_b", b1, WRAP_B);
        step(1);  chk("sweep_b_clear", b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
